// File: rtl/tree_adder.sv
// Two-level pipelined adder tree: op1 = a+b, op2 = c+d, then sum = op1+op2.
// Every adder is a ripple chain of full-adder cells; carry-out becomes the extra result bit.
module tree_adder #(
    parameter int WA = 4,
    parameter int WC = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [WA-1:0] a,
    input  logic [WA-1:0] b,
    input  logic [WC-1:0] c,
    input  logic [WC-1:0] d,
    output logic [WA:0]   op1,
    output logic [WC:0]   op2,
    output logic          op_valid,
    output logic [WC+1:0] sum,
    output logic          sum_valid
);

    logic [WA:0]   op1_d, op1_q;
    logic [WC:0]   op2_d, op2_q;
    logic [WC+1:0] sum_d, sum_q;
    logic          op_valid_q, sum_valid_q;
    logic [WC:0]   op1_x;

    // Each cell owns its carry-out; the next cell picks it up by name, so no chain vector loops on itself.
    for (genvar i = 0; i < WA; i++) begin : g_fa1
        logic ci, co;
        if (i == 0) begin : g_lsb
            assign ci = 1'b0;
        end else begin : g_mid
            assign ci = g_fa1[i-1].co;
        end
        assign op1_d[i] = a[i] ^ b[i] ^ ci;
        assign co       = (a[i] & b[i]) | (ci & (a[i] ^ b[i]));
    end
    assign op1_d[WA] = g_fa1[WA-1].co;

    for (genvar i = 0; i < WC; i++) begin : g_fa2
        logic ci, co;
        if (i == 0) begin : g_lsb
            assign ci = 1'b0;
        end else begin : g_mid
            assign ci = g_fa2[i-1].co;
        end
        assign op2_d[i] = c[i] ^ d[i] ^ ci;
        assign co       = (c[i] & d[i]) | (ci & (c[i] ^ d[i]));
    end
    assign op2_d[WC] = g_fa2[WC-1].co;

    // Stage 2 adds the registered partials; op1 is zero-extended to op2's width.
    assign op1_x = {{(WC-WA){1'b0}}, op1_q};

    for (genvar i = 0; i <= WC; i++) begin : g_fa3
        logic ci, co;
        if (i == 0) begin : g_lsb
            assign ci = 1'b0;
        end else begin : g_mid
            assign ci = g_fa3[i-1].co;
        end
        assign sum_d[i] = op1_x[i] ^ op2_q[i] ^ ci;
        assign co       = (op1_x[i] & op2_q[i]) | (ci & (op1_x[i] ^ op2_q[i]));
    end
    assign sum_d[WC+1] = g_fa3[WC].co;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op1_q       <= '0;
            op2_q       <= '0;
            op_valid_q  <= 1'b0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            if (in_valid) begin
                op1_q <= op1_d;
                op2_q <= op2_d;
            end
            op_valid_q <= in_valid;
            if (op_valid_q) begin
                sum_q <= sum_d;
            end
            sum_valid_q <= op_valid_q;
        end
    end

    assign op1       = op1_q;
    assign op2       = op2_q;
    assign op_valid  = op_valid_q;
    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_tree_adder.sv
// Directed bench for tree_adder: reset, latency, streaming, max values, bubbles, mid-stream reset.
module tb_tree_adder;
    localparam int WA = 4;
    localparam int WC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [WA-1:0] a, b;
    logic [WC-1:0] c, d;
    logic [WA:0]   op1;
    logic [WC:0]   op2;
    logic          op_valid;
    logic [WC+1:0] sum;
    logic          sum_valid;

    int n_chk  = 0;
    int n_pass = 0;

    tree_adder #(.WA(WA), .WC(WC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d),
        .op1(op1), .op2(op2), .op_valid(op_valid),
        .sum(sum), .sum_valid(sum_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int ai, input int bi, input int ci, input int di);
        in_valid = v;
        a = WA'(ai);
        b = WA'(bi);
        c = WC'(ci);
        d = WC'(di);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".op1"}, 32'(op1), 0);
        chk({tag, ".op2"}, 32'(op2), 0);
        chk({tag, ".opv"}, 32'(op_valid), 0);
        chk({tag, ".sum"}, 32'(sum), 0);
        chk({tag, ".sv"},  32'(sum_valid), 0);
    endtask

    int sa [3] = '{10, 15, 0};
    int sb [3] = '{13, 15, 9};
    int sc [3] = '{9, 109, 45};
    int sd [3] = '{10, 37, 45};
    int e1 [3] = '{23, 30, 9};
    int e2 [3] = '{19, 146, 90};
    int es [3] = '{42, 176, 99};

    initial begin
        rst = 1'b1;
        drive(1'b1, 5, 5, 5, 5);
        step();
        step();
        chk_zero("rst_init");
        drive(1'b0, 0, 0, 0, 0);
        rst = 1'b0;
        step();

        // single transaction
        drive(1'b1, 0, 3, 1, 255);
        step();
        drive(1'b0, 0, 0, 0, 0);
        chk("single.op1", 32'(op1), 3);
        chk("single.op2", 32'(op2), 256);
        chk("single.opv", 32'(op_valid), 1);
        chk("single.sv0", 32'(sum_valid), 0);
        step();
        chk("single.sum", 32'(sum), 259);
        chk("single.sv",  32'(sum_valid), 1);
        chk("single.opv0", 32'(op_valid), 0);
        chk("single.op1hold", 32'(op1), 3);
        step();

        // back-to-back stream
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, sa[k], sb[k], sc[k], sd[k]);
            step();
            chk($sformatf("strm%0d.op1", k), 32'(op1), 32'(e1[k]));
            chk($sformatf("strm%0d.op2", k), 32'(op2), 32'(e2[k]));
            chk($sformatf("strm%0d.opv", k), 32'(op_valid), 1);
            if (k > 0) begin
                chk($sformatf("strm%0d.sum", k - 1), 32'(sum), 32'(es[k-1]));
                chk($sformatf("strm%0d.sv", k - 1), 32'(sum_valid), 1);
            end
        end
        drive(1'b0, 0, 0, 0, 0);
        step();
        chk("strm2.sum", 32'(sum), 99);
        chk("strm2.sv",  32'(sum_valid), 1);
        chk("strm.opv0", 32'(op_valid), 0);
        step();

        // maximum operands
        drive(1'b1, 15, 15, 255, 255);
        step();
        drive(1'b0, 0, 0, 0, 0);
        chk("max.op1", 32'(op1), 30);
        chk("max.op2", 32'(op2), 510);
        step();
        chk("max.sum", 32'(sum), 540);
        chk("max.sv",  32'(sum_valid), 1);
        step();

        // bubble: valid, idle, valid
        drive(1'b1, 1, 2, 3, 4);
        step();
        drive(1'b0, 9, 9, 9, 9);
        chk("bub.op1a", 32'(op1), 3);
        step();
        chk("bub.sum_a", 32'(sum), 10);
        chk("bub.sv_a",  32'(sum_valid), 1);
        chk("bub.opv_idle", 32'(op_valid), 0);
        chk("bub.op1hold", 32'(op1), 3);
        drive(1'b1, 5, 6, 7, 8);
        step();
        drive(1'b0, 0, 0, 0, 0);
        chk("bub.sv_idle",  32'(sum_valid), 0);
        chk("bub.sumhold",  32'(sum), 10);
        chk("bub.op2b",     32'(op2), 15);
        step();
        chk("bub.sum_b", 32'(sum), 26);
        chk("bub.sv_b",  32'(sum_valid), 1);
        step();

        // reset mid-stream with two transactions in flight
        drive(1'b1, 2, 2, 2, 2);
        step();
        drive(1'b1, 3, 3, 3, 3);
        chk("mid.opv_pre", 32'(op_valid), 1);
        #2 rst = 1'b1;
        #1 chk_zero("mid.async");
        step();
        step();
        chk_zero("mid.held");
        drive(1'b0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        step();
        chk("mid.sv0", 32'(sum_valid), 0);
        chk("mid.opv0", 32'(op_valid), 0);
        step();
        chk("mid.sv1", 32'(sum_valid), 0);
        drive(1'b1, 1, 1, 1, 1);
        step();
        drive(1'b0, 0, 0, 0, 0);
        chk("post.op1", 32'(op1), 2);
        chk("post.op2", 32'(op2), 2);
        chk("post.sv0", 32'(sum_valid), 0);
        step();
        chk("post.sum", 32'(sum), 4);
        chk("post.sv",  32'(sum_valid), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tree_adder.md
Name: tree_adder

Overview:
- Two-level pipelined adder tree that sums four unsigned operands: two narrow (a, b) and two wide (c, d).
- Level 1 forms the partial sums op1 = a+b and op2 = c+d. Level 2 forms sum = op1+op2.
- Partial sums and the final sum are exposed as registered outputs with valid flags.
- Used as a reduction stage in arithmetic datapaths and for partial-sum debug.

Parameters:
- WA, 4, width of a and b (unsigned).
- WC, 8, width of c and d (unsigned); requirement WC >= WA.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  a/b/c/d valid this cycle.
- a  in  WA  operand A.
- b  in  WA  operand B.
- c  in  WC  operand C.
- d  in  WC  operand D.
- op1  out  WA+1  registered a+b.
- op2  out  WC+1  registered c+d.
- op_valid  out  1  op1/op2 valid.
- sum  out  WC+2  registered op1+op2.
- sum_valid  out  1  sum valid.

Behaviour:
- Reset: rst high asynchronously clears op1, op2, op_valid, sum and sum_valid to 0. Clearing is immediate, with no clock edge needed. Outputs stay 0 while rst is high.
- All arithmetic is unsigned and lossless, with no wrap or saturation anywhere:
  - op1 = zero-extended a + b; maximum 2*(2^WA-1) fits in WA+1 bits.
  - op2 = zero-extended c + d; fits in WC+1 bits.
  - sum = zero-extended op1 + zero-extended op2; fits in WC+2 bits (10 bits at defaults, maximum 540).
- Stage 1, on each rising clk edge with rst low:
  - If in_valid is 1, op1 and op2 capture the new partial sums.
  - If in_valid is 0, op1 and op2 hold their previous values.
  - op_valid <= in_valid.
- Stage 2, on each rising clk edge with rst low:
  - If op_valid is 1, sum <= op1 + op2 (the registered stage-1 values).
  - If op_valid is 0, sum holds its previous value.
  - sum_valid <= op_valid.
- Latency and throughput:
  - op1/op2 appear 1 cycle after inputs are sampled.
  - sum appears 2 cycles after.
  - Throughput is one operand set per cycle, and back-to-back in_valid is fully pipelined.
  - There is no backpressure or ready signal; the consumer must accept each result when its valid flag is high.
- Gaps: a bubble (in_valid=0) propagates as op_valid=0 and then sum_valid=0. Data registers hold their values during bubbles.
- Reset mid-operation: all in-flight results are discarded. The first valid output after release of rst comes from inputs sampled at or after the first clk edge with rst low.
- Adders are implemented as parameterised ripple-carry chains of full-adder cells (generate loops). Carry out of the MSB becomes the extra result bit.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately, and they remain 0 until rst is released.
- Single transaction a=0, b=3, c=1, d=255, in_valid for 1 cycle:
  - 1 cycle later: op1=3, op2=256, op_valid=1.
  - 2 cycles later: sum=259, sum_valid=1.
- Back-to-back stream on consecutive cycles, inputs (10,13,9,10), (15,15,109,37), (0,9,45,45):
  - op1/op2 sequence: 23/19, 30/146, 9/90.
  - sum sequence: 42, 176, 99.
  - Valids high continuously.
- Maximum values a=b=15, c=d=255 -> op1=30, op2=510, sum=540; no overflow.
- Bubble: valid, idle, valid -> sum_valid pattern 1,0,1; sum holds its value during the idle cycle.
- Reset mid-stream: rst pulsed while two transactions are in flight -> neither result emerges (sum_valid stays 0); a new transaction after release completes with correct latency.
